// File: rtl/countdown_timer.sv
// countdown_timer: BCD mm:ss down-counter with a digit-by-digit preset,
// 1 Hz decrement, expiry flag/strobe and restart from the preset.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN (reload from the preset on
// expiry and keep running instead of entering DONE).
module countdown_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       paused,
    input  logic       adj,
    input  logic [1:0] adj_sel,
    input  logic [3:0] adj_val,
    output logic [3:0] min_l,
    output logic [3:0] min_r,
    output logic [3:0] sec_l,
    output logic [3:0] sec_r,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse
);

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned SEL_W    = 2;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX   = DIGIT_W'(9);
    localparam logic [DIGIT_W-1:0] SEC_L_MAX   = DIGIT_W'(5);
    localparam logic [SEL_W-1:0]   SEL_MIN_L   = SEL_W'(0);
    localparam logic [SEL_W-1:0]   SEL_MIN_R   = SEL_W'(1);
    localparam logic [SEL_W-1:0]   SEL_SEC_L   = SEL_W'(2);

    // Digit layout shared by the live count and the preset.
    typedef struct packed {
        logic [DIGIT_W-1:0] min_l;
        logic [DIGIT_W-1:0] min_r;
        logic [DIGIT_W-1:0] sec_l;
        logic [DIGIT_W-1:0] sec_r;
    } bcd_time_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t    state, state_nxt;
    bcd_time_t cur_q, cur_nxt;
    bcd_time_t preset_q, preset_nxt;
    bcd_time_t cur_dec;

    logic               running_nxt;
    logic               expired_nxt;
    logic               pulse_nxt;
    logic               cur_zero;
    logic               preset_zero;
    logic               dec_zero;
    logic               adj_en;
    logic               step_en;
    logic [DIGIT_W-1:0] adj_clamped;

    // Clamp the adjust value: sec_l tops out at 5, every other digit at 9.
    always_comb begin
        adj_clamped = adj_val;
        if (adj_sel == SEL_SEC_L) begin
            if (adj_val > SEC_L_MAX) adj_clamped = SEC_L_MAX;
        end else begin
            if (adj_val > DIGIT_MAX) adj_clamped = DIGIT_MAX;
        end
    end

    // One-second BCD decrement with borrow; only used when the count is nonzero.
    always_comb begin
        cur_dec = cur_q;
        if (cur_q.sec_r != '0) begin
            cur_dec.sec_r = cur_q.sec_r - DIGIT_W'(1);
        end else begin
            cur_dec.sec_r = DIGIT_MAX;
            if (cur_q.sec_l != '0) begin
                cur_dec.sec_l = cur_q.sec_l - DIGIT_W'(1);
            end else begin
                cur_dec.sec_l = SEC_L_MAX;
                if (cur_q.min_r != '0) begin
                    cur_dec.min_r = cur_q.min_r - DIGIT_W'(1);
                end else begin
                    cur_dec.min_r = DIGIT_MAX;
                    cur_dec.min_l = cur_q.min_l - DIGIT_W'(1);
                end
            end
        end
    end

    // Shared qualifiers: adjust is only honoured outside RUN; a step needs an
    // unpaused tick in RUN with no competing start.
    always_comb begin
        cur_zero    = (cur_q == '0);
        preset_zero = (preset_q == '0);
        dec_zero    = (cur_dec == '0);
        adj_en      = adj && (state != ST_RUN);
        step_en     = (state == ST_RUN) && !start && tick && !paused;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic, priority adj > start > tick.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!adj_en && start && !cur_zero) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (start) begin
                    state_nxt = ST_IDLE;
                end else if (step_en && dec_zero) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                    // A zero preset (possible after a stop and re-adjust) must
                    // not keep running at 00:00, so park in IDLE instead.
                    state_nxt = preset_zero ? ST_IDLE : ST_RUN;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                if (adj_en)                       state_nxt = ST_IDLE;
                else if (start && !preset_zero)   state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and flag next values.
    always_comb begin
        cur_nxt    = cur_q;
        preset_nxt = preset_q;
        pulse_nxt  = 1'b0;
        if (adj_en) begin
            case (adj_sel)
                SEL_MIN_L: begin cur_nxt.min_l = adj_clamped; preset_nxt.min_l = adj_clamped; end
                SEL_MIN_R: begin cur_nxt.min_r = adj_clamped; preset_nxt.min_r = adj_clamped; end
                SEL_SEC_L: begin cur_nxt.sec_l = adj_clamped; preset_nxt.sec_l = adj_clamped; end
                default:   begin cur_nxt.sec_r = adj_clamped; preset_nxt.sec_r = adj_clamped; end
            endcase
        end else if (step_en) begin
            cur_nxt = cur_dec;
            if (dec_zero) begin
                pulse_nxt = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                cur_nxt = preset_q;
`endif
            end
        end else if ((state == ST_DONE) && start && !preset_zero) begin
            cur_nxt = preset_q;
        end
        running_nxt = (state_nxt == ST_RUN) && !paused;
        expired_nxt = (state_nxt == ST_DONE);
    end

    // Registered digits, preset and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q        <= '0;
            preset_q     <= '0;
            running      <= 1'b0;
            expired      <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            cur_q        <= cur_nxt;
            preset_q     <= preset_nxt;
            running      <= running_nxt;
            expired      <= expired_nxt;
            expire_pulse <= pulse_nxt;
        end
    end

    assign min_l = cur_q.min_l;
    assign min_r = cur_q.min_r;
    assign sec_l = cur_q.sec_l;
    assign sec_r = cur_q.sec_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed test-plan sequences followed
// by random stimulus, checked against a seconds-based reference model.
module tb_countdown_timer;

    logic       clk = 1'b1;
    logic       rst = 1'b0, tick = 1'b0, start = 1'b0, paused = 1'b0, adj = 1'b0;
    logic [1:0] adj_sel = '0;
    logic [3:0] adj_val = '0;
    logic [3:0] min_l, min_r, sec_l, sec_r;
    logic       running, expired, expire_pulse;

    always #5 clk = ~clk;

    countdown_timer dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .paused(paused),
        .adj(adj), .adj_sel(adj_sel), .adj_val(adj_val),
        .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
        .running(running), .expired(expired), .expire_pulse(expire_pulse)
    );

    typedef struct {
        logic [15:0] digits;
        logic        running;
        logic        expired;
        logic        pulse;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   active = 0;
    int   cyc = 0;

    // Reference model: digits as integers, time as total seconds.
    int m_d[4];
    int m_p[4];
    int m_mode;           // 0 idle, 1 run, 2 done
    bit m_pulse, m_running, m_expired;

    function automatic int to_secs(input int d0, input int d1, input int d2, input int d3);
        return (d0 * 10 + d1) * 60 + d2 * 10 + d3;
    endfunction

    task automatic model_step(input bit r, input bit t, input bit s, input bit p,
                              input bit a, input int sel, input int val);
        int secs;
        int v;
        if (r) begin
            for (int i = 0; i < 4; i++) begin m_d[i] = 0; m_p[i] = 0; end
            m_mode = 0; m_pulse = 0; m_running = 0; m_expired = 0;
            return;
        end
        m_pulse = 0;
        if (a && m_mode != 1) begin
            v = (sel == 2) ? ((val > 5) ? 5 : val) : ((val > 9) ? 9 : val);
            m_d[sel] = v;
            m_p[sel] = v;
            if (m_mode == 2) m_mode = 0;
        end else if (m_mode == 0) begin
            if (s && to_secs(m_d[0], m_d[1], m_d[2], m_d[3]) != 0) m_mode = 1;
        end else if (m_mode == 1) begin
            if (s) begin
                m_mode = 0;
            end else if (t && !p) begin
                secs = to_secs(m_d[0], m_d[1], m_d[2], m_d[3]) - 1;
                m_d[0] = (secs / 60) / 10;
                m_d[1] = (secs / 60) % 10;
                m_d[2] = (secs % 60) / 10;
                m_d[3] = (secs % 60) % 10;
                if (secs == 0) begin
                    m_pulse = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    if (to_secs(m_p[0], m_p[1], m_p[2], m_p[3]) != 0)
                        for (int i = 0; i < 4; i++) m_d[i] = m_p[i];
                    else
                        m_mode = 0;
`else
                    m_mode = 2;
`endif
                end
            end
        end else begin
            if (s && to_secs(m_p[0], m_p[1], m_p[2], m_p[3]) != 0) begin
                for (int i = 0; i < 4; i++) m_d[i] = m_p[i];
                m_mode = 1;
            end
        end
        m_running = (m_mode == 1) && !p;
        m_expired = (m_mode == 2);
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs.
    task automatic apply(input bit r, input bit t, input bit s, input bit p,
                         input bit a, input int sel, input int val);
        exp_t e;
        @(negedge clk);
        rst = r; tick = t; start = s; paused = p; adj = a;
        adj_sel = 2'(sel); adj_val = 4'(val);
        active = 1;
        model_step(r, t, s, p, a, sel, val);
        e.digits  = {4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3])};
        e.running = m_running;
        e.expired = m_expired;
        e.pulse   = m_pulse;
        sb_q.push_back(e);
    endtask

    task automatic do_rst();                 apply(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_idle();                apply(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_adj(input int sel, input int val); apply(0, 0, 0, 0, 1, sel, val); endtask
    task automatic do_start();               apply(0, 0, 1, 0, 0, 0, 0); endtask
    task automatic do_tick(input bit p);     apply(0, 1, 0, p, 0, 0, 0); endtask

    // Monitor: every cycle the DUT presents a fresh registered result.
    initial begin
        exp_t e;
        logic [15:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (active) begin
                cyc++;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty cyc=%0d no expected entry", cyc);
                end else begin
                    e = sb_q.pop_front();
                    got = {min_l, min_r, sec_l, sec_r};
                    checks++;
                    if (got !== e.digits) begin
                        errors++;
                        $display("FAIL digits cyc=%0d got=%h exp=%h", cyc, got, e.digits);
                    end
                    checks++;
                    if ({running, expired, expire_pulse} !== {e.running, e.expired, e.pulse}) begin
                        errors++;
                        $display("FAIL flags cyc=%0d got run/exp/pulse=%b%b%b exp=%b%b%b",
                                 cyc, running, expired, expire_pulse,
                                 e.running, e.expired, e.pulse);
                    end
                end
            end
        end
    end

    initial begin
        int v;
        // Borrow chain
        do_rst();
        do_adj(0, 1); do_adj(1, 0); do_adj(2, 0); do_adj(3, 5);
        do_start();
        repeat (5) do_tick(0);
        do_tick(0);
        do_start();
        do_adj(0, 9); do_adj(1, 9); do_adj(2, 5); do_adj(3, 9);
        do_start(); do_tick(0); do_start();
        // Clamp
        do_adj(2, 9); do_adj(3, 15); do_adj(0, 12); do_adj(1, 10);
        // Expiry
        do_rst(); do_adj(3, 2); do_start(); do_tick(0); do_tick(0); do_idle();
        repeat (3) do_tick(0);
        do_start(); do_idle();
        // Pause and stop
        do_rst(); do_adj(2, 3); do_start();
        repeat (10) do_tick(1);
        do_tick(0); do_start(); do_tick(0); do_tick(0); do_start(); do_tick(0);
        // Edge cases
        do_rst(); do_start();
        do_adj(2, 1); apply(0, 1, 1, 0, 0, 0, 0); do_tick(0);
        do_adj(0, 7); apply(0, 1, 1, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 1, 3, 4);
        // Reset mid-run and reload
        do_rst(); do_adj(1, 5); do_start(); do_tick(0); do_rst();
        do_adj(3, 1); do_start(); do_tick(0); do_idle(); do_tick(0);

        // Random phase; small digit values keep expiry reachable.
        for (int n = 0; n < 4000; n++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(0, 2));
            apply($urandom_range(0, 199) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 3)), v);
        end
        do_idle();

        @(posedge clk);
        #2;
        active = 0;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain leftover=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
